// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Two-port arbiter that lets an instruction-fetch port and a data port share
//   one single-outstanding memory. A winning request is granted
//   combinationally while the arbiter is idle. The memory strobe is issued in
//   that same grant cycle, and the response comes back MEM_LAT cycles later.
//
// Parameters
//   MEM_LAT  cycles from grant to memory response (1..7)
//   DPRIO    1: data port wins every tie; 0: round-robin on ties
//
// Ports
//   clk, rst                     clock and asynchronous active-low reset
//   i_req, i_addr                fetch request and address
//   i_gnt, i_rvalid, i_rdata     fetch grant and read response
//   d_req, d_we, d_addr,
//   d_wdata, d_size              data-port request fields
//   d_gnt, d_done, d_rdata       data grant, completion and read data
//   m_en, m_we, m_addr,
//   m_wdata, m_size              memory request strobe and fields
//   m_rdata                      memory read data
//   busy                         a transaction is outstanding
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int MEM_LAT = 2,
    parameter bit DPRIO   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_size,
    output logic        d_gnt,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        m_en,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [1:0]  m_size,
    input  logic [31:0] m_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

    state_t     state;
    logic [2:0] lat_cnt;
    logic       last_d;     // 1 when the most recent grant went to the data port
    logic       txn_we;     // write flag of the in-flight data transaction
    logic       can_grant;
    logic       tie_to_d;
    logic       grant_i;
    logic       grant_d;
    logic       resp;

    // Arbitration. Grants are only possible while idle and out of reset. The
    // rst term keeps every output low during reset, even with requests
    // present. On a tie in round-robin mode the port that did not win last
    // time is chosen, so after reset (last winner = fetch) data goes first.
    always_comb begin
        can_grant = (state == IDLE) && rst;
        tie_to_d  = DPRIO ? 1'b1 : !last_d;
        grant_d   = can_grant && d_req && (!i_req || tie_to_d);
        grant_i   = can_grant && i_req && !grant_d;
    end

    // The counter reaches 1 in the cycle that lies MEM_LAT cycles after the
    // grant. That cycle is the response cycle.
    assign resp = (state != IDLE) && (lat_cnt == 3'd1);

    // Memory request fields are driven only in the grant cycle. A fetch is
    // always a full-word read.
    always_comb begin
        m_en    = grant_i || grant_d;
        m_we    = grant_d && d_we;
        m_addr  = 32'd0;
        m_wdata = 32'd0;
        m_size  = 2'd0;
        if (grant_d) begin
            m_addr  = d_addr;
            m_wdata = d_wdata;
            m_size  = d_size;
        end else if (grant_i) begin
            m_addr  = i_addr;
            m_size  = 2'd3;
        end
    end

    // Responses are valid only in the response cycle. Writes return zero data.
    always_comb begin
        i_gnt    = grant_i;
        d_gnt    = grant_d;
        i_rvalid = resp && (state == BUSY_I);
        d_done   = resp && (state == BUSY_D);
        i_rdata  = i_rvalid ? m_rdata : 32'd0;
        d_rdata  = (d_done && !txn_we) ? m_rdata : 32'd0;
        busy     = (state != IDLE);
    end

    // Transaction FSM. A grant loads the latency counter. The counter then
    // counts down, and the FSM leaves the busy state in the edge that follows
    // the response cycle. Reset abandons any in-flight transaction without
    // producing a response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            lat_cnt <= 3'd0;
            last_d  <= 1'b0;
            txn_we  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state   <= BUSY_D;
                        lat_cnt <= LAT_INIT;
                        last_d  <= 1'b1;
                        txn_we  <= d_we;
                    end else if (grant_i) begin
                        state   <= BUSY_I;
                        lat_cnt <= LAT_INIT;
                        last_d  <= 1'b0;
                        txn_we  <= 1'b0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (lat_cnt == 3'd1) begin
                        state   <= IDLE;
                        lat_cnt <= 3'd0;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    lat_cnt <= 3'd0;
                end
            endcase
        end
    end

endmodule
